// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule constants, FSM state encoding and the small-sigma functions.
// Pure combinational helpers; no state.
package sha256_pkg;

  localparam int BLOCK_WORDS = 16;
  localparam int SCHED_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_e;

  function automatic logic [31:0] sigma0_small(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1_small(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-input and schedule-output handshake bundle of the message-schedule generator.
// slave = schedule generator side, master = producer/consumer side.
interface sha256_msg_schedule_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_word_valid;
  logic [WIDTH-1:0] i_word;
  logic             o_word_ready;
  logic             o_w_valid;
  logic [WIDTH-1:0] o_w;
  logic [5:0]       o_t;
  logic             i_w_ready;
  logic             o_busy;
  logic             o_done;

  modport slave (
    input  i_start, i_word_valid, i_word, i_w_ready,
    output o_word_ready, o_w_valid, o_w, o_t, o_busy, o_done
  );

  modport master (
    output i_start, i_word_valid, i_word, i_w_ready,
    input  o_word_ready, o_w_valid, o_w, o_t, o_busy, o_done
  );
endinterface

// File: rtl/reduce4to2_nbit.sv
// Four-operand carry-save reducer: a+b+c+d == o_s+o_c (mod 2^WIDTH), o_c already shifted.
// Purely combinational, two layers of 3:2 full adders.
module reduce4to2_nbit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_c
);
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] c1;

  assign s1  = i_a ^ i_b ^ i_c;
  assign c1  = ((i_a & i_b) | (i_a & i_c) | (i_b & i_c)) << 1;
  assign o_s = s1 ^ c1 ^ i_d;
  assign o_c = ((s1 & c1) | (s1 & i_d) | (c1 & i_d)) << 1;
endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then emits W0..W63 one per cycle, W0 two cycles after the last load.
// Output is a single register stage; a stalled consumer holds o_w/o_t and pauses expansion.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sha256_msg_schedule_if.slave  bus
);

  state_e           state_q, state_d;
  logic [3:0]       ld_cnt_q, ld_cnt_d;
  logic [6:0]       t_q, t_d;
  logic             w_vld_q, w_vld_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [5:0]       t_out_q, t_out_d;
  logic [WIDTH-1:0] buf_q [BLOCK_WORDS];

  logic             buf_we;
  logic [3:0]       buf_waddr;
  logic [WIDTH-1:0] buf_wdata;
  logic             done;

  logic [3:0]       idx, idx_m2, idx_m7, idx_m15;
  logic [WIDTH-1:0] op_a, op_b, op_c, op_d;
  logic [WIDTH-1:0] csa_s, csa_c, w_exp, w_new;
  logic             t_is_low, out_hs, issue;

  // Ring indices: t-16 aliases t itself, t-15 aliases t+1.
  assign idx     = t_q[3:0];
  assign idx_m2  = idx - 4'd2;
  assign idx_m7  = idx - 4'd7;
  assign idx_m15 = idx + 4'd1;

  assign op_a = sigma1_small(buf_q[idx_m2]);
  assign op_b = buf_q[idx_m7];
  assign op_c = sigma0_small(buf_q[idx_m15]);
  assign op_d = buf_q[idx];

  reduce4to2_nbit #(.WIDTH(WIDTH)) u_reduce (
    .i_a (op_a),
    .i_b (op_b),
    .i_c (op_c),
    .i_d (op_d),
    .o_s (csa_s),
    .o_c (csa_c)
  );

  assign w_exp    = csa_s + csa_c;
  assign t_is_low = (t_q < 7'(BLOCK_WORDS));
  assign w_new    = t_is_low ? buf_q[idx] : w_exp;

  assign out_hs = w_vld_q & bus.i_w_ready;
  assign issue  = (state_q == EXPAND) && (t_q < 7'(SCHED_WORDS)) && (!w_vld_q || bus.i_w_ready);

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    t_d       = t_q;
    w_vld_d   = w_vld_q;
    w_d       = w_q;
    t_out_d   = t_out_q;
    buf_we    = 1'b0;
    buf_waddr = ld_cnt_q;
    buf_wdata = bus.i_word;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d  = LOAD;
          ld_cnt_d = '0;
          t_d      = '0;
        end
      end
      LOAD: begin
        if (bus.i_word_valid) begin
          buf_we   = 1'b1;
          ld_cnt_d = ld_cnt_q + 4'd1;
          if (ld_cnt_q == 4'(BLOCK_WORDS - 1)) state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (out_hs) begin
          w_vld_d = 1'b0;
          if (t_out_q == 6'(SCHED_WORDS - 1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
        if (issue) begin
          w_vld_d = 1'b1;
          w_d     = w_new;
          t_out_d = t_q[5:0];
          t_d     = t_q + 7'd1;
          // Expanded words overwrite the slot of W[t-16], which is no longer needed.
          if (!t_is_low) begin
            buf_we    = 1'b1;
            buf_waddr = idx;
            buf_wdata = w_exp;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ld_cnt_q <= '0;
      t_q      <= '0;
      w_vld_q  <= 1'b0;
      w_q      <= '0;
      t_out_q  <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      t_q      <= t_d;
      w_vld_q  <= w_vld_d;
      w_q      <= w_d;
      t_out_q  <= t_out_d;
      if (buf_we) buf_q[buf_waddr] <= buf_wdata;
    end
  end

  assign bus.o_word_ready = (state_q == LOAD);
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_w_valid    = w_vld_q;
  assign bus.o_w          = w_q;
  assign bus.o_t          = t_out_q;
  assign bus.o_done       = done;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: a reference schedule is pushed per block
// and popped on every output handshake.
module tb_sha256_msg_schedule;

  typedef logic [31:0] blk_t   [16];
  typedef logic [31:0] sched_t [64];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_msg_schedule_if #(.WIDTH(32)) mif ();

  sha256_msg_schedule #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (mif)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  bit          bp_mode = 1'b0;
  logic [37:0] sb [$];
  logic [31:0] cap_w [64];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_w;
  logic [5:0]  prev_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic ref_sched(input blk_t blk, output sched_t w);
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[i];
      else w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
  endtask

  // Consumer: always ready, or ready about 30% of cycles.
  initial forever begin
    @(posedge clk);
    #1;
    mif.i_w_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Output monitor: scoreboard pop on handshake, stall stability, done pulses.
  initial forever begin
    logic [37:0] e;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {mif.o_w_valid, mif.o_t, mif.o_w}, {1'b1, prev_t, prev_w});
      if (mif.o_w_valid && mif.i_w_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk($sformatf("W%0d", e[37:32]), {mif.o_t, mif.o_w}, e);
        end
        cap_w[mif.o_t] = mif.o_w;
        if (mif.o_t == 6'd63) chk("done_pulse", mif.o_done, 1);
      end
      if (mif.o_done) done_cnt++;
      prev_stall = mif.o_w_valid && !mif.i_w_ready;
      prev_w     = mif.o_w;
      prev_t     = mif.o_t;
    end
  end

  task automatic send_block(input blk_t blk, input int gap, input bit start_mid);
    sched_t w;
    ref_sched(blk, w);
    for (int i = 0; i < 64; i++) sb.push_back({6'(i), w[i]});
    done_cnt = 0;
    mif.i_start = 1'b1;
    @(posedge clk); #1;
    mif.i_start = 1'b0;
    chk("ready_rise", mif.o_word_ready, 1);
    for (int i = 0; i < 16; i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      mif.i_word_valid = 1'b1;
      mif.i_word       = blk[i];
      if (start_mid && i == 5) mif.i_start = 1'b1;
      @(posedge clk); #1;
      mif.i_word_valid = 1'b0;
      mif.i_start      = 1'b0;
    end
    chk("ready_drop", {mif.o_word_ready, mif.o_busy, mif.o_w_valid}, {1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk("first_out", {mif.o_w_valid, mif.o_t}, {1'b1, 6'd0});
  endtask

  task automatic wait_done(input int pulse_at);
    int n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (mif.o_done) break;
      mif.i_start = (n == pulse_at);
      if (n == pulse_at) chk("busy_expand", mif.o_busy, 1);
      n++;
    end
    mif.i_start = 1'b0;
    if (n >= 3000) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    chk("idle_after_done", {mif.o_busy, mif.o_w_valid}, 2'b00);
    chk("done_count", done_cnt, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    blk_t abc, zero, rnd, ones;
    int   n;
    for (int i = 0; i < 16; i++) begin
      abc[i]  = 32'h0;
      zero[i] = 32'h0;
      rnd[i]  = $urandom;
      ones[i] = 32'hFFFF_FFFF;
    end
    abc[0]  = 32'h6162_6380;
    abc[15] = 32'h0000_0018;

    rst_n            = 1'b0;
    mif.i_start      = 1'b0;
    mif.i_word_valid = 1'b0;
    mif.i_word       = '0;
    mif.i_w_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {mif.o_word_ready, mif.o_w_valid, mif.o_busy, mif.o_done, mif.o_t, mif.o_w}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" block with known schedule words
    send_block(abc, 0, 0);
    wait_done(-1);
    chk("abc_W16", cap_w[16], 32'h6162_6380);
    chk("abc_W17", cap_w[17], 32'h000F_0000);
    chk("abc_W18", cap_w[18], 32'h7DA8_6405);
    chk("abc_W63", cap_w[63], 32'h12B1_EDEB);

    // all-zero block
    send_block(zero, 0, 0);
    wait_done(-1);

    // random backpressure on "abc"
    bp_mode = 1'b1;
    send_block(abc, 0, 0);
    wait_done(-1);
    chk("bp_W63", cap_w[63], 32'h12B1_EDEB);
    bp_mode = 1'b0;

    // input valid every third cycle
    send_block(rnd, 2, 0);
    wait_done(-1);

    // start pulses during LOAD and EXPAND are ignored
    send_block(abc, 0, 1);
    wait_done(20);

    // reset at o_t = 30, then an all-ones block
    send_block(abc, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mif.o_w_valid && mif.o_t == 6'd30) && n < 500);
    if (n >= 500) chk("t30_timeout", 64'd0, 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {mif.o_word_ready, mif.o_w_valid, mif.o_busy, mif.o_done, mif.o_t, mif.o_w}, 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(ones, 0, 0);
    wait_done(-1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

SHA-256 message-schedule generator: accepts one 512-bit block as 16 32-bit words over a valid/ready input and emits the 64 schedule words W0..W63 over a valid/ready output. It sits directly upstream of the compression round datapath. For t ≥ 16 it forms the four W-recurrence operands, compresses them with the four-operand carry-save reducer `reduce4to2_nbit`, and resolves the result with one carry-propagate add.

## Interface
- `WIDTH`, default 32: word width; only 32 is supported.
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_start`  in  1  starts a block; sampled only in IDLE.
- `i_word_valid`  in  1  input word valid.
- `i_word`  in  32  message word; big-endian word order, W0 first.
- `o_word_ready`  out  1  high only in LOAD.
- `o_w_valid`  out  1  `o_w` holds a valid schedule word.
- `o_w`  out  32  schedule word W[t].
- `o_t`  out  6  index t of `o_w`.
- `i_w_ready`  in  1  downstream accepts `o_w`.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_done`  out  1  one-cycle pulse on the cycle W63 is accepted.

## Operation
- Storage: 16×32 circular buffer `buf`. Counters: `ld_cnt` (4 bits), `t` (7 bits).
- **IDLE**
  - `i_start` = 1 → go to LOAD; clear `ld_cnt` and `t`.
- **LOAD**
  - Each cycle with `i_word_valid & o_word_ready`: write `buf[ld_cnt] <= i_word`, then increment `ld_cnt`.
  - After the 16th word is accepted → go to EXPAND.
- **EXPAND**
  - Issue condition: `t < 64` and the output register is empty or is being drained this cycle (`!o_w_valid | i_w_ready`). When it holds, compute W[t], load it into the output register with `o_t = t`, set `o_w_valid`, and increment `t`.
  - t < 16: W[t] = `buf[t]`.
  - t ≥ 16, indices mod 16:
    - W[t] = σ1(`buf[t-2]`) + `buf[t-7]` + σ0(`buf[t-15]`) + `buf[t-16]`, mod 2^32.
    - Write W[t] back to `buf[t mod 16]` in the same cycle.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Adder path:
    - `reduce4to2_nbit` produces `o_s`/`o_c`, with `o_c` already weight-aligned.
    - W = `o_s + o_c` mod 2^32.
    - The carry out of bit 31 is discarded.
  - Handshake with `o_t = 63` (i.e. `o_w_valid & i_w_ready`) → pulse `o_done`, clear `o_w_valid`, go to IDLE.
- Handshake rules:
  - `o_w`/`o_t` are held stable while `o_w_valid & !i_w_ready`.
  - `o_w_valid` never drops without a handshake, except on reset.
- `i_start` outside IDLE is ignored.
- `i_word_valid` outside LOAD is ignored.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `buf`, `ld_cnt`, `t` cleared.
- Start to LOAD: `o_word_ready` rises the cycle after `i_start` is sampled.
- LOAD takes a minimum of 16 cycles. `o_word_ready` drops the cycle after the 16th handshake.
- First output: W0 valid on the second cycle after the 16th input handshake; the first cycle is the LOAD→EXPAND transition.
- Throughput: one word per cycle while `i_w_ready` = 1. Minimum 64 cycles from first `o_w_valid` to `o_done`.
- Critical path:
  - σ mux → 4:2 CSA → 32-bit CPA → output register and `buf` write.
  - No internal pipelining.
  - The W[t-2] dependency is satisfied because `buf` is written in the issue cycle, and W[t+1] reads W[t-1] from a prior cycle.
- Reset mid-operation (any state): asynchronous return to IDLE, outputs 0, partial block discarded.
- `o_done` is never asserted together with `o_word_ready`.

## Structure
- Package `sha256_pkg` holds:
  - state encoding constants IDLE/LOAD/EXPAND;
  - `BLOCK_WORDS` = 16 and `SCHED_WORDS` = 64;
  - functions `sigma0_small` and `sigma1_small`.
- Sub-modules:
  - `reduce4to2_nbit` with `WIDTH` = 32, reused unchanged.
  - The CPA stays inline as a `+`.

## Test plan
- **"abc" block**
  - Stimulus: W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018.
  - Expected: W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405, W63 = 0x12B1EDEB; `o_t` runs 0..63; single `o_done`.
- **All-zero block**
  - Expected: all 64 W = 0; carry path never sets a bit.
- **Random backpressure**
  - Stimulus: `i_w_ready` random at 30% duty on the "abc" block.
  - Expected: identical W sequence; `o_w` stable on every stalled cycle; no lost or duplicated `o_t`.
- **Gappy input**
  - Stimulus: `i_word_valid` asserted every third cycle.
  - Expected: exactly 16 words captured; W0..W15 echo the inputs in order.
- **Reset mid-operation**
  - Stimulus: `i_rst_n` low at `o_t` = 30 of "abc"; after release, restart with an all-0xFFFFFFFF block.
  - Expected: outputs 0 during reset; the new sequence matches the reference model with W16 = 0xFFFFFFFF-derived value from the model and no stale words.
- **Start while busy**
  - Stimulus: `i_start` pulsed during LOAD and EXPAND.
  - Expected: no effect; `o_busy` stays 1 until `o_done`; `i_start` in the cycle after `o_done` starts a new LOAD.
